// File: rtl/lsu_front.sv
// Load/store front end: one outstanding CPU access, legality check, dmem drive.
module lsu_front (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_datain,
    output logic [2:0]  dm_memop,
    output logic        dm_we,
    input  logic [31:0] dm_dataout,
    output logic [7:0]  err_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 3;
    localparam int unsigned CNTW = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_ERR   = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [OPW-1:0]    memop_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              hs_c;
    logic              illegal_c;

    // Handshake only possible while idle
    assign hs_c = req_valid && (state_q == S_IDLE);

    // Reject undefined memops, unsigned stores and misaligned half/word accesses
    always_comb begin
        illegal_c = 1'b0;
        case (req_memop)
            3'b011, 3'b110, 3'b111: illegal_c = 1'b1;
            3'b001, 3'b101:         illegal_c = req_addr[0];
            3'b010:                 illegal_c = |req_addr[1:0];
            default:                illegal_c = 1'b0;
        endcase
        if (req_we && req_memop[2]) begin
            illegal_c = 1'b1;
        end
    end

    // Next-state and per-state controls
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        dm_we      = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (illegal_c)   state_d = S_ERR;
                    else if (req_we) state_d = S_WRITE;
                    else             state_d = S_READ;
                end
            end
            S_READ: begin
                rdata_d = dm_dataout;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_WRITE: begin
                dm_we   = 1'b1;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                if (cnt_q != {CNTW{1'b1}}) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Request capture on handshake; held for the whole access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            memop_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (hs_c) begin
            we_q    <= req_we;
            memop_q <= req_memop;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response data, error flag and saturating error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dm_addr    = addr_q;
    assign dm_datain  = wdata_q;
    assign dm_memop   = memop_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q && (state_q == S_RESP);
    assign err_count  = cnt_q;

    // we_q is captured for completeness of the request record only
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_front.sv
// Directed bench for lsu_front with a small byte-addressed dmem model.
module tb_lsu_front;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_datain;
    logic [2:0]  dm_memop;
    logic        dm_we;
    logic [31:0] dm_dataout;
    logic [7:0]  err_count;

    int n_total;
    int n_bad;

    lsu_front dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_memop  (req_memop),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_datain  (dm_datain),
        .dm_memop   (dm_memop),
        .dm_we      (dm_we),
        .dm_dataout (dm_dataout),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian dmem model: combinational extended read, write on rising edge
    logic [7:0] mem [0:255];
    logic [7:0] ma;
    always_comb begin
        ma = dm_addr[7:0];
        case (dm_memop)
            3'b000:  dm_dataout = {{24{mem[ma][7]}}, mem[ma]};
            3'b100:  dm_dataout = {24'h0, mem[ma]};
            3'b001:  dm_dataout = {{16{mem[8'(ma + 8'd1)][7]}}, mem[8'(ma + 8'd1)], mem[ma]};
            3'b101:  dm_dataout = {16'h0, mem[8'(ma + 8'd1)], mem[ma]};
            default: dm_dataout = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                                   mem[8'(ma + 8'd1)], mem[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (dm_we) begin
            mem[ma] <= dm_datain[7:0];
            if (dm_memop[1:0] != 2'b00) mem[8'(ma + 8'd1)] <= dm_datain[15:8];
            if (dm_memop[1:0] == 2'b10) begin
                mem[8'(ma + 8'd2)] <= dm_datain[23:16];
                mem[8'(ma + 8'd3)] <= dm_datain[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access: wait for ready, handshake, then scramble req_* and watch the response
    task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output int we_cnt,
                           output logic err, output logic [31:0] rd,
                           output logic [31:0] s_addr, output logic [2:0] s_op,
                           output logic [31:0] s_data);
        lat = -1; we_cnt = 0; err = 1'b0; rd = 32'hX;
        s_addr = 32'hX; s_op = 3'bX; s_data = 32'hX;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_memop = 3'b000;
        req_addr = ~addr; req_wdata = ~wd;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dm_we) begin
                we_cnt++;
                s_addr = dm_addr; s_op = dm_memop; s_data = dm_datain;
            end
            if (resp_valid) begin
                lat = k; err = resp_err; rd = resp_rdata;
                break;
            end
        end
    endtask

    int          lat, wc;
    logic        er;
    logic [31:0] rd, sa, sd;
    logic [2:0]  so;
    int          seen_resp;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0; n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_memop = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        // Asynchronous reset takes effect before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_dm_we",   32'(dm_we), 32'd0);
        chk("rst_rvalid",  32'(resp_valid), 32'd0);
        chk("rst_rerr",    32'(resp_err), 32'd0);
        chk("rst_rdata",   resp_rdata, 32'd0);
        chk("rst_errcnt",  32'(err_count), 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_op",   32'(dm_memop), 32'd0);
        chk("rst_dm_din",  dm_datain, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_ready", 32'(req_ready), 32'd1);

        // sw 0xDEADBEEF to 0x10
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, wc, er, rd, sa, so, sd);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wecnt", 32'(wc), 32'd1);
        chk("sw_addr", sa, 32'h10);
        chk("sw_op", 32'(so), 32'd2);
        chk("sw_data", sd, 32'hDEADBEEF);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);

        // lbu 0x13 -> 0xDE
        run_req(1'b0, 3'b100, 32'h13, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lbu_lat", 32'(lat), 32'd2);
        chk("lbu_wecnt", 32'(wc), 32'd0);
        chk("lbu_err", 32'(er), 32'd0);
        chk("lbu_rdata", rd, 32'h000000DE);

        // lb 0x13 sign-extends
        run_req(1'b0, 3'b000, 32'h13, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lb_rdata", rd, 32'hFFFFFFDE);

        // lhu / lh 0x12
        run_req(1'b0, 3'b101, 32'h12, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lhu_rdata", rd, 32'h0000DEAD);
        run_req(1'b0, 3'b001, 32'h12, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lh_rdata", rd, 32'hFFFFDEAD);

        // rdata holds after the response
        @(negedge clk);
        chk("rdata_hold", resp_rdata, 32'hFFFFDEAD);

        // lw misaligned -> error
        run_req(1'b0, 3'b010, 32'h12, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lwmis_lat", 32'(lat), 32'd2);
        chk("lwmis_wecnt", 32'(wc), 32'd0);
        chk("lwmis_err", 32'(er), 32'd1);
        chk("lwmis_rdata", rd, 32'd0);
        chk("lwmis_cnt", 32'(err_count), 32'd1);

        // lh odd address -> error
        run_req(1'b0, 3'b001, 32'h11, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lhmis_err", 32'(er), 32'd1);
        chk("lhmis_cnt", 32'(err_count), 32'd2);

        // store with memop[2]=1 -> error, no write
        run_req(1'b1, 3'b100, 32'h10, 32'h55, lat, wc, er, rd, sa, so, sd);
        chk("sbu_err", 32'(er), 32'd1);
        chk("sbu_wecnt", 32'(wc), 32'd0);
        chk("sbu_cnt", 32'(err_count), 32'd3);

        // word still intact at 0x10
        run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);

        // 256 illegal memop 111 requests: counter saturates
        for (int i = 0; i < 256; i++) begin
            run_req(1'b0, 3'b111, 32'h0, 32'h0, lat, wc, er, rd, sa, so, sd);
            chk("sat_err", 32'(er), 32'd1);
        end
        chk("sat_cnt", 32'(err_count), 32'hFF);
        run_req(1'b0, 3'b110, 32'h0, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("sat_hold", 32'(err_count), 32'hFF);

        // Back-to-back loads with req_valid held high
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        req_valid = 1'b1; req_we = 1'b0; req_memop = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(req_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i == 1) begin
                req_addr = 32'h44;
                #1 chk("b2b_addr_hold", dm_addr, 32'h10);
            end
            if (i == 2) begin
                chk("b2b_rv1", 32'(resp_valid), 32'd1);
                chk("b2b_rd1", resp_rdata, 32'hDEADBEEF);
            end
            if (i == 4) chk("b2b_addr2", dm_addr, 32'h44);
            if (i == 5) begin
                chk("b2b_rv2", 32'(resp_valid), 32'd1);
                chk("b2b_rd2", resp_rdata, 32'h0);
            end
        end
        req_valid = 1'b0;

        // Reset in the middle of a WRITE cycle aborts it
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_we_pre", 32'(dm_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_we", 32'(dm_we), 32'd0);
        chk("abort_rv", 32'(resp_valid), 32'd0);
        chk("abort_cnt", 32'(err_count), 32'd0);
        chk("abort_addr", dm_addr, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1 chk("abort_ready", 32'(req_ready), 32'd1);
        seen_resp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen_resp++;
        end
        chk("abort_noresp", 32'(seen_resp), 32'd0);
        run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, wc, er, rd, sa, so, sd);
        chk("abort_nowrite", rd, 32'h0);
        chk("abort_lat", 32'(lat), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
